// File: rtl/vp_spm_responder.sv
// VP scratchpad responder: 1R1W SPM array with fixed-latency reads, VP-priority host port.
// Optional build macro VP_SPM_RANGE_CHK_EN suppresses out-of-range accesses and raises a sticky o_err.
module vp_spm_responder #(
    parameter int DWIDTH     = 512,
    parameter int AWIDTH     = 16,
    parameter int DEPTH      = 4096,
    parameter int MEMR_DELAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vp_rden,
    input  logic [AWIDTH-1:0] i_vp_rdaddr,
    input  logic              i_vp_wren,
    input  logic [AWIDTH-1:0] i_vp_wraddr,
    input  logic [DWIDTH-1:0] i_vp_wdata,
    output logic [DWIDTH-1:0] o_vp_rdata,
    output logic              o_vp_rvld,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [AWIDTH-1:0] i_host_addr,
    input  logic [DWIDTH-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvld,
    output logic [DWIDTH-1:0] o_host_rdata,
    output logic              o_err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              host_rd, host_wr;
    logic              rd_en, wr_en, wr_commit;
    logic              rd_ok, wr_ok;
    logic [AWIDTH-1:0] rd_addr, wr_addr;
    logic [IW-1:0]     rd_idx, wr_idx;
    logic [DWIDTH-1:0] wr_data, rd_data_c;
    logic [DWIDTH-1:0] data_pre;
    logic              vp_vld_pre, host_vld_pre;
    logic              unused_addr_hi;

    // The VP owns any port it requests; the host only fills the idle one.
    assign o_host_gnt = ~rst & i_host_req & (i_host_we ? ~i_vp_wren : ~i_vp_rden);
    assign host_rd    = o_host_gnt & ~i_host_we;
    assign host_wr    = o_host_gnt & i_host_we;

    assign rd_en   = i_vp_rden | host_rd;
    assign rd_addr = i_vp_rden ? i_vp_rdaddr : i_host_addr;
    assign wr_en   = i_vp_wren | host_wr;
    assign wr_addr = i_vp_wren ? i_vp_wraddr : i_host_addr;
    assign wr_data = i_vp_wren ? i_vp_wdata : i_host_wdata;

    assign rd_idx = rd_addr[IW-1:0];
    assign wr_idx = wr_addr[IW-1:0];

    // Upper address bits only matter to the range check; addresses otherwise wrap.
    assign unused_addr_hi = ^{rd_addr, wr_addr, rd_en};

`ifdef VP_SPM_RANGE_CHK_EN
    localparam logic [AWIDTH:0] DEPTH_X = (AWIDTH+1)'(DEPTH);
    logic err_q;

    assign rd_ok = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_ok = ({1'b0, wr_addr} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((rd_en & ~rd_ok) | (wr_en & ~wr_ok)) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
    assign o_err = 1'b0;
`endif

    assign wr_commit = wr_en & wr_ok;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Write-first: a same-cycle write to the read index is forwarded around the array.
    always_comb begin
        rd_data_c = '0;
        if (!rd_ok) begin
            rd_data_c = '0;
        end else if (wr_commit && (wr_idx == rd_idx)) begin
            rd_data_c = wr_data;
        end else begin
            rd_data_c = mem[rd_idx];
        end
    end

    generate
        if (MEMR_DELAY == 1) begin : g_lat1
            assign data_pre     = rd_data_c;
            assign vp_vld_pre   = i_vp_rden;
            assign host_vld_pre = host_rd;
        end else begin : g_latn
            logic [DWIDTH-1:0]     rd_data_pn [MEMR_DELAY-1];
            logic [MEMR_DELAY-2:0] vp_vld_pn;
            logic [MEMR_DELAY-2:0] host_vld_pn;

            // p0 = registered array read; p1.. = delay stages up to the output register.
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    rd_data_pn[0] <= rd_data_c;
                end
                for (int k = 1; k < MEMR_DELAY-1; k++) begin
                    rd_data_pn[k] <= rd_data_pn[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vp_vld_pn   <= '0;
                    host_vld_pn <= '0;
                end else begin
                    vp_vld_pn[0]   <= i_vp_rden;
                    host_vld_pn[0] <= host_rd;
                    for (int k = 1; k < MEMR_DELAY-1; k++) begin
                        vp_vld_pn[k]   <= vp_vld_pn[k-1];
                        host_vld_pn[k] <= host_vld_pn[k-1];
                    end
                end
            end

            assign data_pre     = rd_data_pn[MEMR_DELAY-2];
            assign vp_vld_pre   = vp_vld_pn[MEMR_DELAY-2];
            assign host_vld_pre = host_vld_pn[MEMR_DELAY-2];
        end
    endgenerate

    // Output stage: per-port data registers hold their value between completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vp_rvld    <= 1'b0;
            o_host_rvld  <= 1'b0;
            o_vp_rdata   <= '0;
            o_host_rdata <= '0;
        end else begin
            o_vp_rvld   <= vp_vld_pre;
            o_host_rvld <= host_vld_pre;
            if (vp_vld_pre) begin
                o_vp_rdata <= data_pre;
            end
            if (host_vld_pre) begin
                o_host_rdata <= data_pre;
            end
        end
    end

endmodule

// File: tb/tb_vp_spm_responder.sv
// Directed bench for vp_spm_responder at default parameters (MEMR_DELAY=2, DEPTH=4096).
module tb_vp_spm_responder;

    localparam int DW = 512;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vp_rden, vp_wren;
    logic [AW-1:0] vp_rdaddr, vp_wraddr;
    logic [DW-1:0] vp_wdata, vp_rdata;
    logic          vp_rvld;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          host_gnt, host_rvld;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [DW-1:0] PAT_A5 = {64{8'hA5}};

    vp_spm_responder dut (
        .clk          (clk),
        .rst          (rst),
        .i_vp_rden    (vp_rden),
        .i_vp_rdaddr  (vp_rdaddr),
        .i_vp_wren    (vp_wren),
        .i_vp_wraddr  (vp_wraddr),
        .i_vp_wdata   (vp_wdata),
        .o_vp_rdata   (vp_rdata),
        .o_vp_rvld    (vp_rvld),
        .i_host_req   (host_req),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_gnt   (host_gnt),
        .o_host_rvld  (host_rvld),
        .o_host_rdata (host_rdata),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vp_rden    = 1'b0;
        vp_rdaddr  = '0;
        vp_wren    = 1'b0;
        vp_wraddr  = '0;
        vp_wdata   = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        // Reset state.
        chk("rst_vp_rvld",    DW'(vp_rvld),   '0);
        chk("rst_host_rvld",  DW'(host_rvld), '0);
        chk("rst_vp_rdata",   vp_rdata,       '0);
        chk("rst_host_rdata", host_rdata,     '0);
        chk("rst_err",        DW'(err),       '0);
        chk("rst_gnt",        DW'(host_gnt),  '0);
        rst = 1'b0;
        tick();

        // Host write 0xA5.. to addr 7, granted immediately.
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'd7; host_wdata = PAT_A5;
        #1 chk("hwr_gnt", DW'(host_gnt), 1);
        tick();
        idle();
        vp_rden = 1'b1; vp_rdaddr = 16'd7;            // VP read at T
        tick();
        idle();
        chk("rd7_early_rvld", DW'(vp_rvld), 0);       // T+1
        tick();
        chk("rd7_rvld", DW'(vp_rvld), 1);             // T+2
        chk("rd7_data", vp_rdata, PAT_A5);
        chk("rd7_host_rvld", DW'(host_rvld), 0);
        tick();
        chk("rd7_pulse_end", DW'(vp_rvld), 0);
        chk("rd7_hold", vp_rdata, PAT_A5);

        // Same-cycle VP write and read of addr 3: write-first.
        vp_wren = 1'b1; vp_wraddr = 16'd3; vp_wdata = DW'(16'h1234);
        vp_rden = 1'b1; vp_rdaddr = 16'd3;
        tick();
        idle();
        tick();
        chk("wf_rvld", DW'(vp_rvld), 1);
        chk("wf_data", vp_rdata, DW'(16'h1234));

        // Host read of addr 7 starved by 10 back-to-back VP reads.
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd7;
        for (int i = 0; i < 10; i++) begin
            vp_rden = 1'b1; vp_rdaddr = 16'd3;
            #1 chk($sformatf("starve_gnt_%0d", i), DW'(host_gnt), 0);
            tick();
        end
        vp_rden = 1'b0;
        #1 chk("starve_release_gnt", DW'(host_gnt), 1);
        chk("starve_no_host_rvld", DW'(host_rvld), 0);
        tick();
        host_req = 1'b0;
        chk("hrd_early_rvld", DW'(host_rvld), 0);
        tick();
        chk("hrd_rvld", DW'(host_rvld), 1);
        chk("hrd_data", host_rdata, PAT_A5);
        tick();
        chk("hrd_pulse_end", DW'(host_rvld), 0);

        // Host write blocked while the VP writes.
        vp_wren = 1'b1; vp_wraddr = 16'd10; vp_wdata = DW'(16'h0A0A);
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'd11; host_wdata = DW'(16'hFFFF);
        #1 chk("hwr_blocked_gnt", DW'(host_gnt), 0);
        tick();
        idle();

        // VP write + host read of addr 9 in one cycle: host sees new data.
        vp_wren = 1'b1; vp_wraddr = 16'd9; vp_wdata = DW'(32'hBEEF);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'd9;
        #1 chk("hrd_wr_gnt", DW'(host_gnt), 1);
        tick();
        idle();
        tick();
        chk("hrd_wf_rvld", DW'(host_rvld), 1);
        chk("hrd_wf_data", host_rdata, DW'(32'hBEEF));
        tick();

        // Reads at T and T+1 with reset at T+1: both dropped.
        vp_rden = 1'b1; vp_rdaddr = 16'd7;
        tick();
        vp_rdaddr = 16'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("flush_vp_rvld",    DW'(vp_rvld),   0);
        chk("flush_vp_rdata",   vp_rdata,       0);
        chk("flush_host_rvld",  DW'(host_rvld), 0);
        chk("flush_host_rdata", host_rdata,     0);
        chk("flush_err",        DW'(err),       0);
        tick();
        chk("flush_rvld_t3", DW'(vp_rvld), 0);
        tick();
        chk("flush_rvld_t4", DW'(vp_rvld), 0);

        // Out-of-range / wrapping address 5000 (aliases 904).
        vp_wren = 1'b1; vp_wraddr = 16'd904; vp_wdata = DW'(16'h5555);
        tick();
        vp_wraddr = 16'd5000; vp_wdata = DW'(16'hC0DE);
        tick();
        idle();
        vp_rden = 1'b1; vp_rdaddr = 16'd5000;
        tick();
        vp_rdaddr = 16'd904;
        tick();
        idle();
        chk("oor_rd5000_rvld", DW'(vp_rvld), 1);
`ifdef VP_SPM_RANGE_CHK_EN
        chk("oor_rd5000_data", vp_rdata, 0);
        chk("oor_err", DW'(err), 1);
`else
        chk("wrap_rd5000_data", vp_rdata, DW'(16'hC0DE));
        chk("wrap_err", DW'(err), 0);
`endif
        tick();
        chk("oor_rd904_rvld", DW'(vp_rvld), 1);
`ifdef VP_SPM_RANGE_CHK_EN
        chk("oor_rd904_data", vp_rdata, DW'(16'h5555));
`else
        chk("wrap_rd904_data", vp_rdata, DW'(16'hC0DE));
`endif
        tick();
        tick();
`ifdef VP_SPM_RANGE_CHK_EN
        chk("oor_err_sticky", DW'(err), 1);
`else
        chk("wrap_err_still0", DW'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
